// File: rtl/axi_lite_master.sv
// AXI-lite initiator: one command in flight, AW/W/B writes and AR/R reads.
// Define AXI_MASTER_TIMEOUT_EN to enable the watchdog that aborts a stalled transaction.
module axi_lite_master #(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic              ACLK,
   input  logic              ARESETn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_write,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] AWADDR,
   output logic              AWVALID,
   input  logic              AWREADY,
   output logic [DATA_W-1:0] WDATA,
   output logic              WVALID,
   input  logic              WREADY,
   input  logic              BVALID,
   output logic              BREADY,
   output logic [ADDR_W-1:0] ARADDR,
   output logic              ARVALID,
   input  logic              ARREADY,
   input  logic [DATA_W-1:0] RDATA,
   input  logic              RVALID,
   output logic              RREADY
);

   typedef enum logic [2:0] {
      StIdle,
      StWr,
      StWrResp,
      StRdAddr,
      StRdData,
      StRsp
   } state_e;

   state_e            state_q, state_d;
   logic              awvalid_q, awvalid_d;
   logic              wvalid_q, wvalid_d;
   logic              arvalid_q, arvalid_d;
   logic [ADDR_W-1:0] awaddr_q, awaddr_d;
   logic [ADDR_W-1:0] araddr_q, araddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_write_q, rsp_write_d;
   logic              rsp_err_q, rsp_err_d;
   logic              hs;
   logic              timeout;

`ifdef AXI_MASTER_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            waiting;

   assign waiting = (state_q == StWr) || (state_q == StWrResp) ||
                    (state_q == StRdAddr) || (state_q == StRdData);
   assign timeout = waiting && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
   // Idle/Rsp hold the counter at zero, so entering a wait state starts fresh.
   assign cnt_d   = (!waiting || hs) ? '0 : cnt_q + 1'b1;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   logic unused_timeout;

   assign timeout        = 1'b0;
   assign unused_timeout = ^{TIMEOUT_CYCLES, hs};
`endif

   always_comb begin
      state_d     = state_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      arvalid_d   = arvalid_q;
      awaddr_d    = awaddr_q;
      araddr_d    = araddr_q;
      wdata_d     = wdata_q;
      rsp_write_d = rsp_write_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      hs          = 1'b0;

      case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               if (cmd_write) begin
                  awaddr_d  = cmd_addr;
                  wdata_d   = cmd_wdata;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = StWr;
               end else begin
                  araddr_d  = cmd_addr;
                  arvalid_d = 1'b1;
                  state_d   = StRdAddr;
               end
            end
         end
         StWr: begin
            if (awvalid_q && AWREADY) begin
               awvalid_d = 1'b0;
               hs        = 1'b1;
            end
            if (wvalid_q && WREADY) begin
               wvalid_d = 1'b0;
               hs       = 1'b1;
            end
            if (!awvalid_d && !wvalid_d) begin
               state_d = StWrResp;
            end
         end
         StWrResp: begin
            if (BVALID) begin
               rsp_write_d = 1'b1;
               rsp_rdata_d = '0;
               hs          = 1'b1;
               state_d     = StRsp;
            end
         end
         StRdAddr: begin
            if (ARREADY) begin
               arvalid_d = 1'b0;
               hs        = 1'b1;
               state_d   = StRdData;
            end
         end
         StRdData: begin
            if (RVALID) begin
               rsp_write_d = 1'b0;
               rsp_rdata_d = RDATA;
               hs          = 1'b1;
               state_d     = StRsp;
            end
         end
         StRsp: begin
            if (rsp_ready) begin
               rsp_err_d = 1'b0;
               state_d   = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // A handshake landing in the same cycle wins over the watchdog.
      if (timeout && !hs) begin
         awvalid_d   = 1'b0;
         wvalid_d    = 1'b0;
         arvalid_d   = 1'b0;
         rsp_write_d = (state_q == StWr) || (state_q == StWrResp);
         rsp_rdata_d = '0;
         rsp_err_d   = 1'b1;
         state_d     = StRsp;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q     <= StIdle;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         awaddr_q    <= '0;
         araddr_q    <= '0;
         wdata_q     <= '0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         arvalid_q   <= arvalid_d;
         awaddr_q    <= awaddr_d;
         araddr_q    <= araddr_d;
         wdata_q     <= wdata_d;
         rsp_write_q <= rsp_write_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign cmd_ready = (state_q == StIdle);
   assign rsp_valid = (state_q == StRsp);
   assign BREADY    = (state_q == StWrResp);
   assign RREADY    = (state_q == StRdData);
   assign AWVALID   = awvalid_q;
   assign WVALID    = wvalid_q;
   assign ARVALID   = arvalid_q;
   assign AWADDR    = awaddr_q;
   assign ARADDR    = araddr_q;
   assign WDATA     = wdata_q;
   assign rsp_write = rsp_write_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule
